// File: rtl/lpif_lp_tx_buffer.sv
// Link-layer-side LPIF transmit buffer: queues beats with framing markers, presents them
// to the PHY with lp_irdy/pl_trdy, and sequences the link state request.
module lpif_lp_tx_buffer #(
    parameter int         LPIF_BUS_WIDTH = 32,
    parameter int         DEPTH          = 4,
    parameter logic [3:0] ST_NOP         = 4'h0,
    parameter logic [3:0] ST_ACTIVE      = 4'h1
) (
    input  logic                        lclk,
    input  logic                        reset_n,
    input  logic                        link_en,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LPIF_BUS_WIDTH-1:0]   in_data,
    input  logic [LPIF_BUS_WIDTH/8-1:0] in_bvalid,
    input  logic [LPIF_BUS_WIDTH/8-1:0] in_tlp_start,
    input  logic [LPIF_BUS_WIDTH/8-1:0] in_tlp_end,
    input  logic [LPIF_BUS_WIDTH/8-1:0] in_dllp_start,
    input  logic [LPIF_BUS_WIDTH/8-1:0] in_dllp_end,
    input  logic [LPIF_BUS_WIDTH/8-1:0] in_tlpedb,
    output logic                        lp_irdy,
    input  logic                        pl_trdy,
    output logic [LPIF_BUS_WIDTH-1:0]   lp_data,
    output logic [LPIF_BUS_WIDTH/8-1:0] lp_valid,
    output logic [LPIF_BUS_WIDTH/8-1:0] lp_tlp_start,
    output logic [LPIF_BUS_WIDTH/8-1:0] lp_tlp_end,
    output logic [LPIF_BUS_WIDTH/8-1:0] lp_dllp_start,
    output logic [LPIF_BUS_WIDTH/8-1:0] lp_dllp_end,
    output logic [LPIF_BUS_WIDTH/8-1:0] lp_tlpedb,
    output logic [3:0]                  lp_state_req,
    input  logic [3:0]                  pl_state_sts,
    input  logic                        pl_exit_cg_req,
    output logic                        lp_exit_cg_ack,
    output logic [$clog2(DEPTH):0]      fill_level,
    output logic [7:0]                  drop_cnt,
    output logic [1:0]                  dbg_state
);

    localparam int W       = LPIF_BUS_WIDTH;
    localparam int BYTES   = LPIF_BUS_WIDTH / 8;
    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = W + 6 * BYTES;

    // Handshakes: a beat moves in on in_valid & in_ready and out on lp_irdy & pl_trdy;
    // once offered, the presented beat holds until taken.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW:0]        wr_ptr, rd_ptr;
    logic [ENTRY_W-1:0] head;
    logic               full, empty, push, pop, ack_q;
    logic [8:0]         drop_sum;

    assign fill_level = wr_ptr - rd_ptr;
    assign full       = (fill_level == (AW+1)'(DEPTH));
    assign empty      = (fill_level == '0);
    assign push       = in_valid & in_ready;
    assign pop        = lp_irdy & pl_trdy;
    assign drop_sum   = {1'b0, drop_cnt} + 9'(fill_level);
    assign dbg_state  = state;

    always_ff @(posedge lclk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        lp_state_req = ST_NOP;
        in_ready     = 1'b0;
        lp_irdy      = 1'b0;
        case (state)
            S_IDLE: if (link_en) state_nxt = S_REQ;
            S_REQ: begin
                lp_state_req = ST_ACTIVE;
                if (!link_en)                        state_nxt = S_IDLE;
                else if (pl_state_sts == ST_ACTIVE)  state_nxt = S_RUN;
            end
            S_RUN: begin
                lp_state_req = ST_ACTIVE;
                in_ready     = ~full;
                lp_irdy      = ~empty;
                if (pl_state_sts != ST_ACTIVE || !link_en) state_nxt = S_FLUSH;
            end
            S_FLUSH: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A flush counts whatever is still queued as dropped, saturating at 8'hFF.
    always_ff @(posedge lclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= '0;
        end else if (state == S_FLUSH) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge lclk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {in_tlpedb, in_dllp_end, in_dllp_start,
                                    in_tlp_end, in_tlp_start, in_bvalid, in_data};
    end

    assign head          = mem[rd_ptr[AW-1:0]];
    assign lp_data       = lp_irdy ? head[0 +: W]             : '0;
    assign lp_valid      = lp_irdy ? head[W +: BYTES]         : '0;
    assign lp_tlp_start  = lp_irdy ? head[W+BYTES +: BYTES]   : '0;
    assign lp_tlp_end    = lp_irdy ? head[W+2*BYTES +: BYTES] : '0;
    assign lp_dllp_start = lp_irdy ? head[W+3*BYTES +: BYTES] : '0;
    assign lp_dllp_end   = lp_irdy ? head[W+4*BYTES +: BYTES] : '0;
    assign lp_tlpedb     = lp_irdy ? head[W+5*BYTES +: BYTES] : '0;

    // The ack follows the request with one cycle of lag, and is forced low outside REQ/RUN.
    always_ff @(posedge lclk or negedge reset_n) begin
        if (!reset_n)                               ack_q <= 1'b0;
        else if (state == S_REQ || state == S_RUN)  ack_q <= pl_exit_cg_req;
        else                                        ack_q <= 1'b0;
    end

    assign lp_exit_cg_ack = ack_q & (state == S_REQ || state == S_RUN);

endmodule
